// File: rtl/lr_rmw_seq.sv
// Read-modify-write sequencer: fetch (HL), one ALU pass, update flags, write back or return the byte.
// Latency 4 (no writeback) / 5 (writeback) cycles with zero-wait memory; one command at a time; LR_RMW_TIMEOUT_EN adds an ack watchdog.
module lr_rmw_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_wb,
    input  logic [3:0]  cmd_fmask,
    input  logic        cmd_swap,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_c,
    input  logic [15:0] alu_d,
    input  logic        alu_z,
    input  logic        alu_h,
    input  logic        alu_cy,
    output logic [3:0]  flags,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        err
);
    localparam logic [4:0] OP_SUB = 5'h07;
    localparam logic [4:0] OP_SBC = 5'h08;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EXEC, S_WR, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  op_q;
    logic [4:0]  alu_op_q;
    logic [15:0] addr_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  b_q;
    logic [7:0]  opnd_q;
    logic [7:0]  result_q;
    logic [7:0]  mem_wdata_q;
    logic        wb_q;
    logic        swap_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic        res_valid_q;
    logic [3:0]  fmask_q;
    logic [3:0]  flags_q;
    logic [3:0]  flags_d;

`ifdef LR_RMW_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    logic [7:0] cnt_q;
    logic       err_q;
    logic       to_hit;
    assign to_hit = (cnt_q + 8'd1) == TO_LIM;
    assign err    = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign err            = 1'b0;
`endif

    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_d[15:8];

    assign cmd_ready = (state_q == S_IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = {8'h00, swap_q ? b_q : opnd_q};
    assign alu_b     = {8'h00, swap_q ? opnd_q : b_q};
    assign alu_c     = flags_q[0];
    assign flags     = flags_q;
    assign res_valid = res_valid_q;
    assign res_data  = result_q;

    // Flag order {Z,N,H,C}; masked-off flags keep their value.
    always_comb begin
        flags_d = flags_q;
        if (fmask_q[3]) flags_d[3] = alu_z;
        if (fmask_q[2]) flags_d[2] = (op_q == OP_SUB) || (op_q == OP_SBC);
        if (fmask_q[1]) flags_d[1] = alu_h;
        if (fmask_q[0]) flags_d[0] = alu_cy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            alu_op_q    <= '0;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            b_q         <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            mem_wdata_q <= '0;
            wb_q        <= 1'b0;
            swap_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            res_valid_q <= 1'b0;
            fmask_q     <= '0;
            flags_q     <= '0;
`ifdef LR_RMW_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q       <= cmd_op;
                        addr_q     <= cmd_addr;
                        b_q        <= cmd_b;
                        wb_q       <= cmd_wb;
                        fmask_q    <= cmd_fmask;
                        swap_q     <= cmd_swap;
                        mem_addr_q <= cmd_addr;
                        mem_rd_q   <= 1'b1;
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        opnd_q   <= mem_rdata;
                        alu_op_q <= op_q;
                        mem_rd_q <= 1'b0;
                        state_q  <= S_EXEC;
                    end
`ifdef LR_RMW_TIMEOUT_EN
                    else if (to_hit) begin
                        mem_rd_q    <= 1'b0;
                        err_q       <= 1'b1;
                        result_q    <= 8'hFF;
                        res_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                S_EXEC: begin
                    result_q <= alu_d[7:0];
                    flags_q  <= flags_d;
                    if (wb_q) begin
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= alu_d[7:0];
                        mem_addr_q  <= addr_q;
                        state_q     <= S_WR;
                    end else begin
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        mem_wr_q    <= 1'b0;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`ifdef LR_RMW_TIMEOUT_EN
                    else if (to_hit) begin
                        mem_wr_q    <= 1'b0;
                        err_q       <= 1'b1;
                        result_q    <= 8'hFF;
                        res_valid_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
`ifdef LR_RMW_TIMEOUT_EN
            // Counter rests at zero outside the bus states, so each RD/WR entry starts fresh.
            if (state_q != S_RD && state_q != S_WR) cnt_q <= '0;
`endif
        end
    end
endmodule

// File: tb/tb_lr_rmw_seq.sv
// Scoreboard bench for lr_rmw_seq: directed commands, behavioural memory and ALU, queued expectations.
module tb_lr_rmw_seq;
`ifdef LR_RMW_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif
    localparam logic [4:0] OP_ADD = 5'h05;
    localparam logic [4:0] OP_SUB = 5'h07;
    localparam logic [4:0] OP_RL  = 5'h0A;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [4:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_b;
    logic        cmd_wb, cmd_swap;
    logic [3:0]  cmd_fmask;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr, mem_ack;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [4:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_d;
    logic        alu_c, alu_z, alu_h, alu_cy;
    logic [3:0]  flags;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        err;

    lr_rmw_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_b(cmd_b), .cmd_wb(cmd_wb), .cmd_fmask(cmd_fmask), .cmd_swap(cmd_swap),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_d(alu_d), .alu_z(alu_z), .alu_h(alu_h), .alu_cy(alu_cy),
        .flags(flags), .res_valid(res_valid), .res_data(res_data), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU for the three opcodes exercised here.
    logic [8:0] alu_r;
    logic       alu_hh;
    always_comb begin
        alu_r  = {1'b0, alu_a[7:0]};
        alu_hh = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_r  = {1'b0, alu_a[7:0]} + {1'b0, alu_b[7:0]};
                alu_hh = ({1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]}) > 5'h0F;
            end
            OP_SUB: begin
                alu_r  = {1'b0, alu_a[7:0]} - {1'b0, alu_b[7:0]};
                alu_hh = alu_a[3:0] < alu_b[3:0];
            end
            OP_RL: begin
                alu_r  = {alu_a[7:0], alu_c};
                alu_hh = 1'b0;
            end
            default: ;
        endcase
    end
    assign alu_d  = {8'h00, alu_r[7:0]};
    assign alu_z  = (alu_r[7:0] == 8'h00);
    assign alu_h  = alu_hh;
    assign alu_cy = alu_r[8];

    logic unused_tb;
    assign unused_tb = ^{alu_a[15:8], alu_b[15:8]};

    typedef struct { logic [7:0] data; logic [3:0] flags; int lat; } exp_t;
    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  expw_q[$];
    int   acc_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Memory model: ack after rd_wait/wr_wait idle request cycles.
    logic [7:0]  mem [0:65535];
    int          rd_wait = 0, wr_wait = 0, wcnt = 0;
    bit          no_ack = 0, spur = 0, active = 0;
    logic [15:0] cap_addr;
    logic        cap_rd;
    logic [7:0]  cap_wdata;
    wr_t         wexp;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'hA5;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 8'hA5;
            if (rst) begin
                wcnt   = 0;
                active = 0;
            end else if (mem_rd || mem_wr) begin
                check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
                if (!active) begin
                    active    = 1;
                    cap_addr  = mem_addr;
                    cap_rd    = mem_rd;
                    cap_wdata = mem_wdata;
                end else begin
                    check("req_addr_stable", 32'(mem_addr), 32'(cap_addr));
                    check("req_kind_stable", 32'({mem_rd, mem_wr}), 32'({cap_rd, ~cap_rd}));
                    if (!cap_rd) check("wdata_stable", 32'(mem_wdata), 32'(cap_wdata));
                end
                if (!no_ack && wcnt == (mem_rd ? rd_wait : wr_wait)) begin
                    mem_ack = 1'b1;
                    active  = 0;
                    wcnt    = 0;
                    if (mem_rd) begin
                        mem_rdata = mem[mem_addr];
                    end else begin
                        mem[mem_addr] = mem_wdata;
                        if (expw_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
                        end else begin
                            wexp = expw_q.pop_front();
                            check("wr_addr", 32'(mem_addr), 32'(wexp.addr));
                            check("wr_data", 32'(mem_wdata), 32'(wexp.data));
                        end
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt    = 0;
                active  = 0;
                mem_ack = spur;
            end
        end
    end

    // Result monitor.
    bit         busy = 0, chk_next = 0;
    logic [7:0] last_res;
    exp_t       e;
    int         acc;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_next) begin
                    check("ready_after_done", 32'(cmd_ready), 32'd1);
                    check("res_data_held", 32'(res_data), 32'(last_res));
                    chk_next = 0;
                end
                if (res_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: got 0x%0h, expected no result", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 32'(res_data), 32'(e.data));
                        check("flags", 32'(flags), 32'(e.flags));
                        acc = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                        if (e.lat != 0) check("latency", 32'(cyc - acc + 1), 32'(e.lat));
                    end
                    last_res = res_data;
                    chk_next = 1;
                    busy     = 0;
                end else if (busy) begin
                    check("ready_low_busy", 32'(cmd_ready), 32'd0);
                end
                if (cmd_valid && cmd_ready) begin
                    acc_q.push_back(cyc);
                    busy = 1;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [15:0] addr, input logic [7:0] b,
                         input logic wb, input logic [3:0] fm, input logic sw,
                         input logic [7:0] xd, input logic [3:0] xf, input int lat, input bit xw);
        exp_t ex;
        wr_t  w;
        int   n;
        ex.data  = xd;
        ex.flags = xf;
        ex.lat   = lat;
        exp_q.push_back(ex);
        if (xw) begin
            w.addr = addr;
            w.data = xd;
            expw_q.push_back(w);
        end
        @(posedge clk);
        #1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_b     = b;
        cmd_wb    = wb;
        cmd_fmask = fm;
        cmd_swap  = sw;
        cmd_valid = 1'b1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
        end
        if (n == 50) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || chk_next) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n == 200) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_b = '0;
        cmd_wb = 1'b0; cmd_fmask = '0; cmd_swap = 1'b0;
        mem[16'h8000] = 8'h20; mem[16'hC000] = 8'h0F; mem[16'h8001] = 8'h01;
        mem[16'hD000] = 8'h80; mem[16'hC100] = 8'h3A; mem[16'hC200] = 8'h01;
        mem[16'h8002] = 8'h05; mem[16'h9000] = 8'h00;

        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // A-op-(HL): SUB, swap, A=0x10, mem=0x20 -> 0xF0, {Z,N,H,C}=0101
        issue(OP_SUB, 16'h8000, 8'h10, 1'b0, 4'hF, 1'b1, 8'hF0, 4'h5, 4, 1'b0);
        wait_idle();
        // INC (HL): 0x0F+1 -> 0x10, C preserved at 1
        issue(OP_ADD, 16'hC000, 8'h01, 1'b1, 4'hE, 1'b0, 8'h10, 4'h3, 5, 1'b1);
        wait_idle();
        check("mem_C000", 32'(mem[16'hC000]), 32'h10);
        // Clear C only: 1+1 -> 2, flags 0010
        issue(OP_ADD, 16'h8001, 8'h01, 1'b0, 4'h1, 1'b0, 8'h02, 4'h2, 4, 1'b0);
        wait_idle();
        // CB RL (HL): 0x80, C=0 -> 0x00, flags 1001
        issue(OP_RL, 16'hD000, 8'h00, 1'b1, 4'hF, 1'b0, 8'h00, 4'h9, 5, 1'b1);
        wait_idle();
        check("mem_D000", 32'(mem[16'hD000]), 32'h00);

        // Stray acks while idle must be ignored.
        spur = 1;
        repeat (3) @(negedge clk);
        spur = 0;
        repeat (2) @(negedge clk);
        check("spur_flags", 32'(flags), 32'h9);
        check("spur_ready", 32'(cmd_ready), 32'd1);
        check("spur_mem_rd", 32'(mem_rd), 32'd0);

        // Wait states: 3 on read, 2 on write; 0x3A+0xC9 -> 0x03, H=1, C=1
        rd_wait = 3;
        wr_wait = 2;
        issue(OP_ADD, 16'hC100, 8'hC9, 1'b1, 4'hF, 1'b0, 8'h03, 4'h3, 10, 1'b1);
        wait_idle();
        check("mem_C100", 32'(mem[16'hC100]), 32'h03);

        // Reset during WR abandons the write.
        rd_wait = 0;
        wr_wait = 3;
        issue(OP_ADD, 16'hC200, 8'h01, 1'b1, 4'h0, 1'b0, 8'h02, 4'h3, 0, 1'b1);
        n = 0;
        while (!mem_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_reached", 32'(mem_wr), 32'd1);
        check("flags_before_rst", 32'(flags), 32'h3);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_wr", 32'(mem_wr), 32'd0);
        check("arst_mem_rd", 32'(mem_rd), 32'd0);
        check("arst_flags", 32'(flags), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        exp_q.delete();
        expw_q.delete();
        acc_q.delete();
        busy = 0;
        chk_next = 0;
        wr_wait = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        check("mem_C200_untouched", 32'(mem[16'hC200]), 32'h01);

        // Normal command after reset: 5-5 -> 0, flags 1100
        issue(OP_SUB, 16'h8002, 8'h05, 1'b0, 4'hF, 1'b0, 8'h00, 4'hC, 4, 1'b0);
        wait_idle();

`ifdef LR_RMW_TIMEOUT_EN
        check("err_before_timeout", 32'(err), 32'd0);
        no_ack = 1;
        issue(OP_ADD, 16'h9000, 8'h01, 1'b1, 4'hF, 1'b0, 8'hFF, 4'hC, 6, 1'b0);
        wait_idle();
        no_ack = 0;
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_ready", 32'(cmd_ready), 32'd1);
        issue(OP_ADD, 16'h9000, 8'h01, 1'b0, 4'hF, 1'b0, 8'h01, 4'h0, 4, 1'b0);
        wait_idle();
        check("err_sticky", 32'(err), 32'd1);
`else
        check("err_tied_low", 32'(err), 32'd0);
`endif

        check("results_drained", 32'(exp_q.size()), 32'd0);
        check("writes_drained", 32'(expw_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lr_rmw_seq.md
Name: lr_rmw_seq

Overview:
- Read-modify-write sequencer for memory-operand ALU instructions: INC/DEC (HL), CB-prefix rotates/shifts/SWAP on (HL), and A-op-(HL) arithmetic.
- Fetches the byte from the memory port, drives one pass through the 8-bit ALU, updates the flag register, then either writes the byte back or returns it to the core.
- Sits between the instruction decoder and the memory bus arbiter; the ALU stays purely combinational.

Parameters:
- TIMEOUT, 255, memory-ack watchdog limit in cycles; used only when LR_RMW_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  5  ALU opcode, ALU encoding (OR=0x00 … SRL=0x0F, SWAP=0x10)
- cmd_addr  in  16  operand address (HL)
- cmd_b  in  8  second ALU operand (A, or 1 for INC/DEC)
- cmd_wb  in  1  1 = write result to memory; 0 = return on res_data
- cmd_fmask  in  4  flag update enable {Z,N,H,C}; 0 bit = flag keeps its value
- cmd_swap  in  1  1 = memory byte drives ALU b, cmd_b drives ALU a (A-op-(HL) form)
- mem_addr  out  16  bus address
- mem_rd  out  1  read request, held until mem_ack
- mem_wr  out  1  write request, held until mem_ack
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe
- alu_op  out  5  ALU opcode
- alu_a  out  16  ALU a, upper byte 0
- alu_b  out  16  ALU b, upper byte 0
- alu_c  out  1  current C flag
- alu_d  in  16  ALU result; bits 7:0 used
- alu_z  in  1  ALU zero indication
- alu_h  in  1  ALU half carry
- alu_cy  in  1  ALU carry
- flags  out  4  {Z,N,H,C} flag register
- res_valid  out  1  one-cycle result strobe
- res_data  out  8  result byte, held until next EXEC
- err  out  1  sticky timeout error (feature only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; cmd_ready=1; mem_rd=mem_wr=0; mem_addr=0; mem_wdata=0; flags=0; res_valid=0; res_data=0; err=0; alu_op=0.
- Reset is asynchronous. Asserting it mid-transaction drops mem_rd/mem_wr in the same cycle, and the pending command is lost.
- IDLE: on cmd_valid, latch op, addr, b, wb, fmask and swap. Next state is RD, with mem_rd=1 and mem_addr=addr.
- RD: hold mem_rd and mem_addr stable until mem_ack. On ack, latch mem_rdata into opnd, deassert mem_rd and go to EXEC. An ack that coincides with entry into RD is valid.
- EXEC (exactly 1 cycle): alu_op=op.
  - swap=0: alu_a={8'h00,opnd}, alu_b={8'h00,b}.
  - swap=1: operands exchanged.
  - alu_c=flags.C.
  - Result register takes alu_d[7:0].
  - Each flag with its fmask bit set loads: Z=alu_z; N=1 for SUB(0x07)/SBC(0x08) and 0 otherwise; H=alu_h; C=alu_cy.
  - Next state: wb=1 goes to WR with mem_wr=1, mem_wdata=result, mem_addr=addr. wb=0 goes to DONE.
- WR: hold mem_wr, mem_wdata and mem_addr until mem_ack, then go to DONE.
- DONE (1 cycle): res_valid=1 and res_data=result, then back to IDLE.
- Latency with zero-wait memory (ack on the cycle after request): 4 cycles when wb=0, 5 when wb=1, from command accept to res_valid.
- mem_ack outside RD/WR is ignored. mem_rd and mem_wr are never both high.
- cmd_valid outside IDLE is not accepted; the decoder holds the command until accepted.
- Flags change only in EXEC. The flags output is the register value.

Optional Feature:
- Macro LR_RMW_TIMEOUT_EN.
- When defined:
  - An 8-bit counter clears on entry to RD/WR and increments each cycle without mem_ack.
  - On reaching TIMEOUT: drop the request, set err (sticky until reset), leave flags unchanged, pulse res_valid with res_data=8'hFF, return to IDLE.
- When undefined: no counter, err tied 0, RD/WR wait indefinitely.

Test Plan:
- INC (HL): op=ADD, b=1, fmask=1110, wb=1, C=1 initially, mem[0xC000]=0x0F -> write 0x10 to 0xC000; flags {Z,N,H,C}={0,0,1,1}; res_valid on cycle 5.
- CB RL (HL): op=RL, fmask=1111, C=0, mem=0x80, wb=1 -> write 0x00; flags={1,0,0,1}.
- A-op-(HL), no writeback: SUB, swap=1, cmd_b(A)=0x10, mem=0x20, wb=0 -> no mem_wr; res_data=0xF0; N=1, C=1.
- Wait states: mem_ack delayed 3 cycles on read and 2 on write -> mem_addr/mem_rd/mem_wr stable throughout; single ack each; cmd_ready low until DONE+1.
- Async reset asserted in WR -> mem_wr low the same cycle; flags=0; cmd_ready=1; the next command executes normally.
- With LR_RMW_TIMEOUT_EN and TIMEOUT=4, no ack -> err=1; res_data=0xFF; flags unchanged; IDLE after the 4th wait cycle.
